trap_printer: RTL and testbench

TRAP_PRINTER -- requirements
Module: trap_printer

---
 rtl/trap_printer.sv | 121 ++++++++++++
 tb/tb_trap_printer.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/trap_printer.sv
// Prints the unsigned value captured on a rising trap edge as ASCII decimal followed by a newline.
// The first byte is offered WIDTH cycles after capture; a byte is held stable until out_ready accepts it.
module trap_printer #(
   parameter int WIDTH  = 32,
   parameter int DIGITS = 10
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             trap,
   input  logic [WIDTH-1:0] value,
   output logic [7:0]       out_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic             busy,
   output logic             dropped
);

   localparam int PW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
   localparam int CW = $clog2(WIDTH + 1);

   typedef enum logic [1:0] {IDLE, CONVERT, EMIT} state_t;

   state_t              state;
   logic                trap_q;
   logic [WIDTH-1:0]    shift_r;
   logic [4*DIGITS-1:0] bcd;
   logic [CW-1:0]       cnt;
   logic [PW-1:0]       ptr;

   logic                trap_edge;
   logic [4*DIGITS-1:0] bcd_adj;
   logic [4*DIGITS-1:0] bcd_nxt;
   logic [WIDTH-1:0]    shift_nxt;
   logic [PW-1:0]       msd;
   logic [3:0]          msd_digit;
   logic [PW-1:0]       ptr_dn;
   logic [3:0]          dn_digit;

   assign trap_edge = trap & ~trap_q;
   assign busy      = (state != IDLE);

   // One double-dabble step: correct digits >= 5, then shift the whole {bcd, shift} pair left.
   always_comb begin
      bcd_adj = bcd;
      for (int i = 0; i < DIGITS; i++) begin
         if (bcd[4*i +: 4] >= 4'd5) begin
            bcd_adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
         end
      end
      {bcd_nxt, shift_nxt} = {bcd_adj, shift_r} << 1;
   end

   // Leading digit of the finished conversion, so the first byte is ready as EMIT is entered.
   always_comb begin
      msd = '0;
      for (int i = 0; i < DIGITS; i++) begin
         if (bcd_nxt[4*i +: 4] != 4'd0) begin
            msd = PW'(i);
         end
      end
   end

   assign msd_digit = bcd_nxt[4*msd +: 4];
   assign ptr_dn    = ptr - PW'(1);
   assign dn_digit  = bcd[4*ptr_dn +: 4];

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= IDLE;
         trap_q    <= 1'b0;
         shift_r   <= '0;
         bcd       <= '0;
         cnt       <= '0;
         ptr       <= '0;
         out_data  <= 8'h00;
         out_valid <= 1'b0;
         dropped   <= 1'b0;
      end else begin
         trap_q  <= trap;
         dropped <= trap_edge && (state != IDLE);
         case (state)
            IDLE: begin
               if (trap_edge) begin
                  shift_r <= value;
                  bcd     <= '0;
                  cnt     <= CW'(WIDTH);
                  state   <= CONVERT;
               end
            end
            CONVERT: begin
               bcd     <= bcd_nxt;
               shift_r <= shift_nxt;
               cnt     <= cnt - CW'(1);
               if (cnt == CW'(1)) begin
                  state     <= EMIT;
                  ptr       <= msd;
                  out_valid <= 1'b1;
                  out_data  <= 8'h30 + {4'h0, msd_digit};
               end
            end
            EMIT: begin
               if (out_ready) begin
                  if (out_data == 8'h0A) begin
                     state     <= IDLE;
                     out_valid <= 1'b0;
                     out_data  <= 8'h00;
                     ptr       <= '0;
                  end else if (ptr == '0) begin
                     out_data <= 8'h0A;
                  end else begin
                     ptr      <= ptr_dn;
                     out_data <= 8'h30 + {4'h0, dn_digit};
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_trap_printer.sv
// Directed bench for trap_printer: collects transferred bytes and compares them to hand-written strings.
module tb_trap_printer;

   logic        clk = 1'b0;
   logic        reset;
   logic        trap;
   logic [31:0] value;
   logic [7:0]  out_data;
   logic        out_valid;
   logic        out_ready;
   logic        busy;
   logic        dropped;

   int          nvec = 0;
   int          nmis = 0;
   logic [7:0]  q[$];
   int          cyc = 0;
   int          first_cyc = 0;
   int          last_cyc = 0;
   int          ndrop = 0;

   trap_printer #(.WIDTH(32), .DIGITS(10)) dut (
      .clk(clk), .reset(reset), .trap(trap), .value(value),
      .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
      .busy(busy), .dropped(dropped)
   );

   always #5 clk = ~clk;

   // Inputs change just after the rising edge, so the falling edge sees what the next edge will act on.
   always @(negedge clk) begin
      cyc++;
      if (dropped) ndrop++;
      if (out_valid && out_ready) begin
         if (q.size() == 0) first_cyc = cyc;
         last_cyc = cyc;
         q.push_back(out_data);
      end
   end

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      nvec++;
      if (got !== exp) begin
         nmis++;
         $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic capture(input logic [31:0] v);
      q.delete();
      value = v;
      trap  = 1'b1;
      tick();
      trap  = 1'b0;
   endtask

   task automatic wait_idle(input string tag);
      int n = 0;
      while (busy && n < 300) begin
         tick();
         n++;
      end
      chk({tag, "_idle_timeout"}, busy, 1'b0);
   endtask

   task automatic wait_byte(input string tag, input logic [7:0] b);
      int n = 0;
      while (!(out_valid === 1'b1 && out_data === b) && n < 300) begin
         tick();
         n++;
      end
      chk({tag, "_wait_byte"}, out_data, b);
   endtask

   task automatic check_stream(input string tag, input string exp);
      logic [7:0] g;
      chk({tag, "_len"}, q.size(), exp.len());
      for (int i = 0; i < exp.len(); i++) begin
         g = (i < q.size()) ? q[i] : 8'h00;
         chk($sformatf("%s_byte%0d", tag, i), g, exp[i]);
      end
   endtask

   initial begin
      reset     = 1'b1;
      trap      = 1'b0;
      value     = 32'd0;
      out_ready = 1'b1;
      repeat (2) tick();
      chk("rst_valid", out_valid, 1'b0);
      chk("rst_data", out_data, 8'h00);
      chk("rst_busy", busy, 1'b0);
      chk("rst_dropped", dropped, 1'b0);

      // trap already high when reset releases counts as an edge; value 0 prints "0\n"
      q.delete();
      trap = 1'b1;
      tick();
      reset = 1'b0;
      tick();
      chk("postrst_edge_busy", busy, 1'b1);
      chk("postrst_edge_dropped", dropped, 1'b0);
      trap = 1'b0;
      wait_idle("zero");
      check_stream("zero", "0\n");
      chk("zero_valid_after", out_valid, 1'b0);

      // first out_valid exactly 32 edges after capture
      capture(32'd25);
      chk("lat_busy", busy, 1'b1);
      chk("lat_valid0", out_valid, 1'b0);
      repeat (31) tick();
      chk("lat_valid31", out_valid, 1'b0);
      chk("lat_data31", out_data, 8'h00);
      tick();
      chk("lat_valid32", out_valid, 1'b1);
      chk("lat_data32", out_data, 8'h32);
      wait_idle("v25");
      check_stream("v25", "25\n");

      // all ones, back to back
      capture(32'hFFFF_FFFF);
      wait_idle("max");
      check_stream("max", "4294967295\n");
      chk("max_back2back", last_cyc - first_cyc, 10);

      // backpressure while '2' is offered; value changes after capture must not matter
      capture(32'd1234);
      value = 32'd0;
      wait_byte("bp", 8'h31);
      tick();
      out_ready = 1'b0;
      for (int i = 0; i < 5; i++) begin
         chk($sformatf("bp_hold_data%0d", i), out_data, 8'h32);
         chk($sformatf("bp_hold_valid%0d", i), out_valid, 1'b1);
         tick();
      end
      out_ready = 1'b1;
      wait_idle("bp");
      check_stream("bp", "1234\n");

      // second edge during CONVERT, then trap held high for 100 cycles
      ndrop = 0;
      capture(32'd777);
      repeat (3) tick();
      value = 32'd555;
      trap  = 1'b1;
      tick();
      chk("drop_pulse", dropped, 1'b1);
      tick();
      chk("drop_pulse_end", dropped, 1'b0);
      repeat (98) tick();
      trap = 1'b0;
      repeat (3) tick();
      chk("drop_busy", busy, 1'b0);
      chk("drop_count", ndrop, 1);
      check_stream("drop", "777\n");

      // trap edge in the same cycle as the newline transfer is dropped
      capture(32'd7);
      wait_byte("nl", 8'h0A);
      trap = 1'b1;
      tick();
      chk("nl_dropped", dropped, 1'b1);
      chk("nl_busy", busy, 1'b0);
      chk("nl_valid", out_valid, 1'b0);
      trap = 1'b0;
      tick();
      chk("nl_dropped_end", dropped, 1'b0);
      chk("nl_no_retrigger", busy, 1'b0);
      check_stream("nl", "7\n");

      // reset during EMIT aborts the print
      capture(32'd987);
      wait_byte("abort", 8'h38);
      chk("abort_pre_len", q.size(), 1);
      reset = 1'b1;
      #1;
      chk("abort_valid", out_valid, 1'b0);
      chk("abort_data", out_data, 8'h00);
      chk("abort_busy", busy, 1'b0);
      tick();
      reset = 1'b0;
      repeat (40) tick();
      chk("abort_no_more", q.size(), 1);
      capture(32'd5);
      wait_idle("five");
      check_stream("five", "5\n");

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
      $finish;
   end

endmodule
